// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO. It has a runtime baud prescaler,
// optional parity and an optional second stop bit. Queued frames go out back-to-back.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                        CLK_TX,
  input  logic                        RST_TX,
  input  logic [DATA_WIDTH-1:0]       P_DATA_TX,
  input  logic                        DATA_VALID_TX,
  output logic                        READY_TX,
  input  logic                        PAR_EN,
  input  logic                        PAR_TYP,
  input  logic                        STOP2,
  input  logic [PRESCALE_W-1:0]       PRESCALE,
  output logic                        TX_OUT,
  output logic                        Busy,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
  output logic                        FRAME_DONE
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wrPtr;
  logic [PW-1:0]         r_rdPtr;
  logic [CW-1:0]         r_count;

  state_t                r_state;
  state_t                w_stateNext;
  logic                  r_tx;
  logic                  w_txNext;
  logic                  w_load;
  logic                  w_frameDone;
  logic                  w_bitEnd;
  logic                  w_full;
  logic                  w_push;
  logic                  w_fifoNonEmpty;
  logic [DATA_WIDTH-1:0] w_head;

  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_bitIdx;
  logic [PRESCALE_W-1:0] r_baudCnt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_parEn;
  logic                  r_stop2;
  logic                  r_parity;

  assign w_full         = (r_count == CW'(FIFO_DEPTH));
  assign w_fifoNonEmpty = (r_count != '0);
  assign w_push         = DATA_VALID_TX && !w_full;
  assign w_head         = r_mem[r_rdPtr];
  assign w_bitEnd       = (r_baudCnt == r_prescale - PRESCALE_W'(1));

  always_ff @(posedge CLK_TX) begin
    if (!RST_TX && w_push) begin
      r_mem[r_wrPtr] <= P_DATA_TX;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge CLK_TX) begin
    if (RST_TX) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_load) r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK_TX) begin
    if (RST_TX) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  // w_txNext is the line level for the state being entered, so TX_OUT stays registered.
  always_comb begin
    w_stateNext = r_state;
    w_txNext    = r_tx;
    w_load      = 1'b0;
    w_frameDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txNext = 1'b1;
        if (w_fifoNonEmpty) begin
          w_load      = 1'b1;
          w_stateNext = S_START;
          w_txNext    = 1'b0;
        end
      end
      S_START: begin
        if (w_bitEnd) begin
          w_stateNext = S_DATA;
          w_txNext    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          if (r_bitIdx == IW'(DATA_WIDTH - 1)) begin
            w_stateNext = r_parEn ? S_PARITY : S_STOP1;
            w_txNext    = r_parEn ? r_parity : 1'b1;
          end else begin
            w_txNext = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = S_STOP1;
          w_txNext    = 1'b1;
        end
      end
      S_STOP1, S_STOP2: begin
        if (w_bitEnd) begin
          if (r_state == S_STOP1 && r_stop2) begin
            w_stateNext = S_STOP2;
            w_txNext    = 1'b1;
          end else begin
            w_frameDone = 1'b1;
            if (w_fifoNonEmpty) begin
              w_load      = 1'b1;
              w_stateNext = S_START;
              w_txNext    = 1'b0;
            end else begin
              w_stateNext = S_IDLE;
              w_txNext    = 1'b1;
            end
          end
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_txNext    = 1'b1;
      end
    endcase
  end

  // Configuration is captured only when a word is loaded, so mid-frame changes wait for the next frame.
  always_ff @(posedge CLK_TX) begin
    if (RST_TX) begin
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bitIdx   <= '0;
      r_baudCnt  <= '0;
      r_prescale <= PRESCALE_W'(1);
      r_parEn    <= 1'b0;
      r_stop2    <= 1'b0;
      r_parity   <= 1'b0;
    end else begin
      r_tx <= w_txNext;
      if (w_load) begin
        r_shift    <= w_head;
        r_bitIdx   <= '0;
        r_baudCnt  <= '0;
        r_prescale <= (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
        r_parEn    <= PAR_EN;
        r_stop2    <= STOP2;
        r_parity   <= (^w_head) ^ PAR_TYP;
      end else if (r_state != S_IDLE) begin
        if (w_bitEnd) begin
          r_baudCnt <= '0;
          if (r_state == S_DATA) begin
            r_shift  <= r_shift >> 1;
            r_bitIdx <= r_bitIdx + IW'(1);
          end
        end else begin
          r_baudCnt <= r_baudCnt + PRESCALE_W'(1);
        end
      end
    end
  end

  assign TX_OUT     = r_tx;
  assign READY_TX   = !w_full;
  assign Busy       = (r_state != S_IDLE) || w_fifoNonEmpty;
  assign FIFO_COUNT = r_count;
  assign FRAME_DONE = w_frameDone;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: an 8-bit instance checked by a serial-line scoreboard,
// plus a 7-bit instance for the narrow-word frame.
module tb_uart_tx_fifo;

  typedef struct {
    logic [7:0]  data;
    logic        parEn;
    logic        parTyp;
    logic        stop2;
    logic [15:0] prescale;
    logic        expParity;
    int          expLen;
  } vec_t;

  typedef struct {
    logic [7:0]  data;
    logic        parEn;
    logic        parity;
    logic        stop2;
    logic [15:0] prescale;
    int          expLen;
  } frameExp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        parEn, parTyp, stop2;
  logic [15:0] prescale;

  logic [7:0]  data8;
  logic        valid8, ready8, tx8, busy8, done8;
  logic [2:0]  count8;

  logic [6:0]  data7;
  logic        valid7, ready7, tx7, busy7, done7;
  logic [2:0]  count7;

  int testsRun    = 0;
  int testsFailed = 0;
  int framesDone  = 0;

  frameExp_t expQ[$];
  int        gapQ[$];

  always #5 clock = ~clock;

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_W(16)) dut8 (
    .CLK_TX(clock), .RST_TX(reset), .P_DATA_TX(data8), .DATA_VALID_TX(valid8),
    .READY_TX(ready8), .PAR_EN(parEn), .PAR_TYP(parTyp), .STOP2(stop2),
    .PRESCALE(prescale), .TX_OUT(tx8), .Busy(busy8), .FIFO_COUNT(count8),
    .FRAME_DONE(done8)
  );

  uart_tx_fifo #(.DATA_WIDTH(7), .FIFO_DEPTH(4), .PRESCALE_W(16)) dut7 (
    .CLK_TX(clock), .RST_TX(reset), .P_DATA_TX(data7), .DATA_VALID_TX(valid7),
    .READY_TX(ready7), .PAR_EN(parEn), .PAR_TYP(parTyp), .STOP2(stop2),
    .PRESCALE(prescale), .TX_OUT(tx7), .Busy(busy7), .FIFO_COUNT(count7),
    .FRAME_DONE(done7)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic modelParity(input logic [7:0] d, input logic typ);
    return (^d) ^ typ;
  endfunction

  function automatic int modelLen(input logic pe, input logic s2, input logic [15:0] ps);
    int p;
    p = (ps == 16'd0) ? 1 : int'(ps);
    return (1 + 8 + int'(pe) + 1 + int'(s2)) * p;
  endfunction

  task automatic pushExp(input logic [7:0] d, input logic pe, input logic pt, input logic s2, input logic [15:0] ps);
    frameExp_t e;
    e.data = d; e.parEn = pe; e.parity = modelParity(d, pt); e.stop2 = s2;
    e.prescale = ps; e.expLen = modelLen(pe, s2, ps);
    expQ.push_back(e);
  endtask

  // Drive one write on the 8-bit instance; called just after a rising edge.
  task automatic applyStimulus(input logic [7:0] d);
    valid8 = 1'b1;
    data8  = d;
    @(posedge clock); #1;
    valid8 = 1'b0;
  endtask

  task automatic waitFrames(input int n, input int budget);
    int i = 0;
    while (framesDone < n && i < budget) begin
      @(posedge clock); #1;
      i++;
    end
    if (framesDone < n) checkOutput("frameTimeout", framesDone, n);
  endtask

  task automatic waitIdle(input int budget);
    int i = 0;
    while ((busy8 !== 1'b0 || tx8 !== 1'b1) && i < budget) begin
      @(posedge clock); #1;
      i++;
    end
    if (i == budget) checkOutput("idleTimeout", busy8, 0);
  endtask

  // Serial-line scoreboard for the 8-bit instance: each start bit pops one expected frame.
  initial begin : monitor
    frameExp_t   e;
    logic [11:0] bitVec;
    int nb, ps, cyc, bad, doneCyc, doneHits, gap;
    bit aborted, junk;
    gap = 0;
    junk = 0;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        expQ.delete();
        gap  = 0;
        junk = 0;
      end else if (tx8 !== 1'b0) begin
        gap++;
        junk = 0;
      end else if (junk) begin
        gap = 0;
      end else if (expQ.size() == 0) begin
        checkOutput("unexpectedFrame", 1, 0);
        junk = 1;
      end else begin
        e = expQ.pop_front();
        bitVec = '0;
        nb = 1;
        for (int i = 0; i < 8; i++) begin bitVec[nb] = e.data[i]; nb++; end
        if (e.parEn) begin bitVec[nb] = e.parity; nb++; end
        bitVec[nb] = 1'b1; nb++;
        if (e.stop2) begin bitVec[nb] = 1'b1; nb++; end
        ps = (e.prescale == 16'd0) ? 1 : int'(e.prescale);
        gapQ.push_back(gap);
        gap = 0;
        bad = 0; cyc = 0; doneCyc = 0; doneHits = 0; aborted = 0;
        for (int b = 0; b < nb && !aborted; b++) begin
          for (int k = 0; k < ps && !aborted; k++) begin
            if (cyc != 0) @(negedge clock);
            if (reset === 1'b1) begin
              aborted = 1;
            end else begin
              cyc++;
              if (tx8 !== bitVec[b] && bad == 0) bad = cyc;
              if (done8 === 1'b1) begin
                doneHits++;
                if (doneCyc == 0) doneCyc = cyc;
              end
            end
          end
        end
        if (aborted) begin
          expQ.delete();
        end else begin
          checkOutput($sformatf("frameBits data=%0h firstBadCycle", e.data), bad, 0);
          checkOutput($sformatf("frameDoneCycle data=%0h", e.data), doneCyc, e.expLen);
          checkOutput($sformatf("frameDoneHits data=%0h", e.data), doneHits, 1);
          framesDone++;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    vec_t        vec[6];
    logic [7:0]  fillWords[6];
    logic [10:0] exp7;
    logic [1:0]  got;
    int          base, doneCyc, cyc, highs, i;
    bit          found;

    vec[0] = '{data: 8'hA5, parEn: 1'b1, parTyp: 1'b0, stop2: 1'b0, prescale: 16'd4, expParity: 1'b0, expLen: 44};
    vec[1] = '{data: 8'h00, parEn: 1'b0, parTyp: 1'b0, stop2: 1'b0, prescale: 16'd0, expParity: 1'b0, expLen: 10};
    vec[2] = '{data: 8'h3C, parEn: 1'b1, parTyp: 1'b1, stop2: 1'b1, prescale: 16'd3, expParity: 1'b1, expLen: 36};
    vec[3] = '{data: 8'h01, parEn: 1'b1, parTyp: 1'b0, stop2: 1'b1, prescale: 16'd1, expParity: 1'b1, expLen: 12};
    vec[4] = '{data: 8'hFF, parEn: 1'b0, parTyp: 1'b0, stop2: 1'b1, prescale: 16'd2, expParity: 1'b0, expLen: 22};
    vec[5] = '{data: 8'h80, parEn: 1'b1, parTyp: 1'b1, stop2: 1'b0, prescale: 16'd5, expParity: 1'b0, expLen: 55};
    fillWords = '{8'h11, 8'h82, 8'h4C, 8'hF0, 8'h3E, 8'h99};

    reset = 1'b1;
    parEn = 1'b0; parTyp = 1'b0; stop2 = 1'b0; prescale = 16'd1;
    data8 = '0; valid8 = 1'b0; data7 = '0; valid7 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    checkOutput("resetTx", tx8, 1);
    checkOutput("resetReady", ready8, 1);
    checkOutput("resetBusy", busy8, 0);
    checkOutput("resetCount", count8, 0);
    checkOutput("resetDone", done8, 0);
    checkOutput("resetTx7", tx7, 1);
    checkOutput("resetBusy7", busy7, 0);
    @(posedge clock); #1;

    $display("[TB] table-driven single frames");
    for (int v = 0; v < 6; v++) begin
      parEn = vec[v].parEn; parTyp = vec[v].parTyp; stop2 = vec[v].stop2; prescale = vec[v].prescale;
      expQ.push_back('{data: vec[v].data, parEn: vec[v].parEn, parity: vec[v].expParity,
                       stop2: vec[v].stop2, prescale: vec[v].prescale, expLen: vec[v].expLen});
      base = framesDone;
      applyStimulus(vec[v].data);
      @(negedge clock);
      checkOutput("latencyIdle", tx8, 1);
      checkOutput("busyQueued", busy8, 1);
      @(negedge clock);
      checkOutput("latencyStart", tx8, 0);
      @(posedge clock); #1;
      waitFrames(base + 1, 200);
      @(negedge clock);
      checkOutput("busyAfterFrame", busy8, 0);
      checkOutput("txIdleAfterFrame", tx8, 1);
      @(posedge clock); #1;
    end

    $display("[TB] FIFO fill and back-to-back frames");
    waitIdle(100);
    parEn = 1'b0; parTyp = 1'b0; stop2 = 1'b0; prescale = 16'd100;
    gapQ.delete();
    base = framesDone;
    for (int w = 0; w < 6; w++) begin
      checkOutput($sformatf("fillReady%0d", w), ready8, (w < 5) ? 1 : 0);
      if (w < 5) pushExp(fillWords[w], 1'b0, 1'b0, 1'b0, 16'd100);
      valid8 = 1'b1;
      data8  = fillWords[w];
      @(posedge clock); #1;
    end
    valid8 = 1'b0;
    checkOutput("fillCount", count8, 4);
    checkOutput("fillReadyLow", ready8, 0);
    waitFrames(base + 5, 6000);
    for (int g = 1; g < 5; g++) begin
      checkOutput($sformatf("fillGap%0d", g), (gapQ.size() > g) ? gapQ[g] : -1, 0);
    end
    waitIdle(100);

    $display("[TB] 7-bit frame with odd parity and two stop bits");
    parEn = 1'b1; parTyp = 1'b1; stop2 = 1'b1; prescale = 16'd2;
    exp7 = 11'b11011111110;
    valid7 = 1'b1;
    data7  = 7'h7F;
    @(posedge clock); #1;
    valid7 = 1'b0;
    found = 0;
    for (i = 0; i < 4 && !found; i++) begin
      @(negedge clock);
      if (tx7 === 1'b0) found = 1;
    end
    checkOutput("dw7StartSeen", found, 1);
    if (found) begin
      cyc = 0;
      doneCyc = 0;
      for (int b = 0; b < 11; b++) begin
        for (int k = 0; k < 2; k++) begin
          if (cyc != 0) @(negedge clock);
          cyc++;
          got[k] = tx7;
          if (done7 === 1'b1 && doneCyc == 0) doneCyc = cyc;
        end
        checkOutput($sformatf("dw7Bit%0d", b), got, {2{exp7[b]}});
      end
      checkOutput("dw7DoneCycle", doneCyc, 22);
      @(negedge clock);
      checkOutput("dw7BusyAfter", busy7, 0);
    end
    @(posedge clock); #1;

    $display("[TB] configuration change mid-frame");
    waitIdle(100);
    parEn = 1'b0; parTyp = 1'b0; stop2 = 1'b0; prescale = 16'd2;
    gapQ.delete();
    base = framesDone;
    pushExp(8'h5A, 1'b0, 1'b0, 1'b0, 16'd2);
    applyStimulus(8'h5A);
    repeat (6) @(posedge clock);
    #1;
    pushExp(8'hC3, 1'b1, 1'b0, 1'b0, 16'd8);
    applyStimulus(8'hC3);
    parEn = 1'b1;
    prescale = 16'd8;
    waitFrames(base + 2, 300);
    checkOutput("cfgGap", (gapQ.size() > 1) ? gapQ[1] : -1, 0);
    waitIdle(100);

    $display("[TB] reset mid-frame with words queued");
    parEn = 1'b0; parTyp = 1'b0; stop2 = 1'b0; prescale = 16'd10;
    for (int w = 0; w < 4; w++) begin
      pushExp(fillWords[w], 1'b0, 1'b0, 1'b0, 16'd10);
      valid8 = 1'b1;
      data8  = fillWords[w];
      @(posedge clock); #1;
    end
    valid8 = 1'b0;
    checkOutput("rstQueued", count8, 3);
    repeat (15) @(posedge clock);
    #1;
    reset  = 1'b1;
    valid8 = 1'b1;
    data8  = 8'hEE;
    @(posedge clock); #1;
    reset  = 1'b0;
    valid8 = 1'b0;
    checkOutput("rstTx", tx8, 1);
    checkOutput("rstCount", count8, 0);
    checkOutput("rstBusy", busy8, 0);
    checkOutput("rstReady", ready8, 1);
    base  = framesDone;
    highs = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (tx8 === 1'b1) highs++;
    end
    checkOutput("rstQuietHighs", highs, 300);
    checkOutput("rstNoFrames", framesDone, base);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
